// File: rtl/ldtu_pkg.sv
// Shared LiTe-DTU constants: word header codes, packer FSM encodings and word-type tags.
// Also imported by the output FIFO top and the packer bench.
package ldtu_pkg;

    localparam logic [1:0] HDR_BASE  = 2'b01;
    localparam logic [3:0] HDR_BPART = 4'b0010;
    localparam logic [5:0] HDR_SIG   = 6'b001010;
    localparam logic [5:0] HDR_SIG1  = 6'b001011;
    localparam logic [3:0] HDR_TRL   = 4'b1101;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BASE = 2'd1;
    localparam logic [1:0] ST_SIG  = 2'd2;

    typedef enum logic [2:0] {
        W_BFULL,
        W_BPART,
        W_SIG,
        W_SIG1,
        W_TRL
    } word_type_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/ldtu_sample_packer_if.sv
// Sample stream in, FIFO-facing word stream out, plus loss status.
// The sample source / FIFO side uses master; the packer uses slave.
interface ldtu_sample_packer_if;

    logic        sample_valid;
    logic [12:0] sample_in;
    logic        flush;
    logic        full_signal;
    logic [31:0] data_out_32;
    logic        write_signal;
    logic        overflow;
    logic [7:0]  drop_cnt;

    modport master (
        output sample_valid, sample_in, flush, full_signal,
        input  data_out_32, write_signal, overflow, drop_cnt
    );

    modport slave (
        input  sample_valid, sample_in, flush, full_signal,
        output data_out_32, write_signal, overflow, drop_cnt
    );

endinterface

// File: rtl/ldtu_pack_word.sv
// Combinational formatter: held samples plus a word-type tag -> one 32-bit output word.
module ldtu_pack_word
    import ldtu_pkg::*;
(
    input  word_type_t  word_type,
    input  logic [29:0] base_bus,   // five 6-bit samples, oldest in [5:0]
    input  logic [2:0]  n,
    input  logic [12:0] sig_a,
    input  logic [12:0] sig_b,
    input  logic [7:0]  trl_id,
    input  logic [11:0] trl_words,
    input  logic [7:0]  trl_drops,
    output logic [31:0] word
);

    logic [23:0] part;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        part = '0;
        for (int i = 0; i < 4; i++) begin
            if (3'(i) < n) part[i*6 +: 6] = base_bus[i*6 +: 6];
        end

        word = '0;
        case (word_type)
            W_BFULL: word = {HDR_BASE, base_bus};
            W_BPART: word = {HDR_BPART, 1'b0, n, part};
            W_SIG:   word = {HDR_SIG, sig_b, sig_a};
            W_SIG1:  word = {HDR_SIG1, 13'd0, sig_a};
            W_TRL:   word = {HDR_TRL, trl_id, trl_words, trl_drops};
            default: word = '0;
        endcase
    end

endmodule

// File: rtl/ldtu_sample_packer.sv
// Packs gain-selected 13-bit samples into 32-bit baseline/signal/trailer words for the output FIFO,
// closing every FRAME_SAMPLES samples with a trailer and accounting for words lost on FIFO full.
module ldtu_sample_packer
    import ldtu_pkg::*;
#(
    parameter int FRAME_SAMPLES = 100,
    parameter int BASE_MAX      = 63
)
(
    input  logic                 CLK,
    input  logic                 reset,
    ldtu_sample_packer_if.slave  bus
);

    localparam logic [11:0] LAST_IDX = 12'(FRAME_SAMPLES - 1);
    localparam logic [12:0] BASE_LIM = 13'(BASE_MAX);

    logic [1:0]       state;
    logic [2:0]       base_cnt;
    logic [3:0][5:0]  base_hold;
    logic [12:0]      sig_hold;
    logic [11:0]      frame_cnt, frame_words, trl_words;
    logic [7:0]       frame_id, trl_id, frame_drops, trl_drops;
    logic             trailer_pend, single_pend, defer_valid;
    logic [31:0]      single_word, defer_word, data_q;
    logic             write_q, out_old, out_trl, overflow_q;
    logic [7:0]       drop_q;

    logic       run, accept, is_base, frame_last, frame_end;
    logic [1:0] state_nxt;
    logic [2:0] cnt_nxt, new_n;
    logic       new_valid, split, incl_cur, hold_sig, add_base;
    word_type_t new_type;
    logic [12:0] sig_a;
    logic [29:0] base_bus;
    logic [31:0] new_word, single_fmt, trl_word, load_word;
    logic [11:0] words_add;
    logic       drop_now, to_frame, to_trl;
    logic [7:0] frame_drops_cur, trl_drops_cur;
    logic       load, load_old, load_trl, take_new;

    assign run        = bus.flush;
    assign accept     = bus.sample_valid & run;
    assign is_base    = bus.sample_in <= BASE_LIM;
    assign frame_last = frame_cnt == LAST_IDX;
    assign frame_end  = accept & frame_last;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = base_cnt;
        new_valid = 1'b0;
        new_type  = W_BFULL;
        new_n     = base_cnt;
        split     = 1'b0;
        incl_cur  = 1'b0;
        hold_sig  = 1'b0;
        add_base  = 1'b0;
        sig_a     = sig_hold;
        if (accept) begin
            case (state)
                ST_IDLE: begin
                    if (is_base) begin
                        incl_cur = 1'b1;
                        if (frame_last) begin
                            new_valid = 1'b1; new_type = W_BPART; new_n = 3'd1;
                        end else begin
                            state_nxt = ST_BASE; cnt_nxt = 3'd1; add_base = 1'b1;
                        end
                    end else if (frame_last) begin
                        new_valid = 1'b1; new_type = W_SIG1; sig_a = bus.sample_in;
                    end else begin
                        state_nxt = ST_SIG; hold_sig = 1'b1;
                    end
                end
                ST_BASE: begin
                    if (is_base) begin
                        incl_cur = 1'b1;
                        if (base_cnt == 3'd4) begin
                            new_valid = 1'b1; state_nxt = ST_IDLE; cnt_nxt = 3'd0;
                        end else if (frame_last) begin
                            new_valid = 1'b1; new_type = W_BPART; new_n = base_cnt + 3'd1;
                            state_nxt = ST_IDLE; cnt_nxt = 3'd0;
                        end else begin
                            cnt_nxt = base_cnt + 3'd1; add_base = 1'b1;
                        end
                    end else begin
                        new_valid = 1'b1; new_type = W_BPART; cnt_nxt = 3'd0;
                        // On the frame's last sample the new signal sample leaves as its own single word.
                        if (frame_last) begin
                            split = 1'b1; state_nxt = ST_IDLE;
                        end else begin
                            state_nxt = ST_SIG; hold_sig = 1'b1;
                        end
                    end
                end
                ST_SIG: begin
                    new_valid = 1'b1; new_type = W_SIG; state_nxt = ST_IDLE;
                end
                default: begin
                    state_nxt = ST_IDLE; cnt_nxt = 3'd0;
                end
            endcase
        end
    end

    always_comb begin
        base_bus = {6'd0, base_hold};
        for (int i = 0; i < 5; i++) begin
            if (incl_cur && base_cnt == 3'(i)) base_bus[i*6 +: 6] = bus.sample_in[5:0];
        end
    end

    assign words_add = {11'd0, new_valid} + {11'd0, split};

    // A drop is charged to the frame its word belongs to; words emitted at a frame end belong to the closing frame.
    assign drop_now        = write_q & bus.full_signal;
    assign to_frame        = drop_now & ~out_trl & ~out_old;
    assign to_trl          = drop_now & ~out_trl & out_old;
    assign frame_drops_cur = to_frame ? sat_inc8(frame_drops) : frame_drops;
    assign trl_drops_cur   = to_trl ? sat_inc8(trl_drops) : trl_drops;

    ldtu_pack_word u_data (
        .word_type(new_type), .base_bus(base_bus), .n(new_n), .sig_a(sig_a), .sig_b(bus.sample_in),
        .trl_id(8'd0), .trl_words(12'd0), .trl_drops(8'd0), .word(new_word)
    );

    ldtu_pack_word u_single (
        .word_type(W_SIG1), .base_bus(30'd0), .n(3'd0), .sig_a(bus.sample_in), .sig_b(13'd0),
        .trl_id(8'd0), .trl_words(12'd0), .trl_drops(8'd0), .word(single_fmt)
    );

    ldtu_pack_word u_trl (
        .word_type(W_TRL), .base_bus(30'd0), .n(3'd0), .sig_a(13'd0), .sig_b(13'd0),
        .trl_id(trl_id), .trl_words(trl_words), .trl_drops(trl_drops_cur), .word(trl_word)
    );

    // Older pending words go out first; a fresh word that loses the slot waits one cycle in the defer register.
    always_comb begin
        load      = 1'b1;
        load_old  = 1'b0;
        load_trl  = 1'b0;
        take_new  = 1'b0;
        load_word = new_word;
        if (single_pend) begin
            load_word = single_word; load_old = 1'b1;
        end else if (trailer_pend) begin
            load_word = trl_word; load_trl = 1'b1;
        end else if (defer_valid) begin
            load_word = defer_word;
        end else if (new_valid) begin
            take_new = 1'b1; load_old = frame_end;
        end else begin
            load = 1'b0;
        end
    end

    // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;       base_cnt <= '0;       base_hold <= '0;    sig_hold <= '0;
            frame_cnt <= '0;        frame_words <= '0;    trl_words <= '0;
            frame_id <= '0;         trl_id <= '0;         frame_drops <= '0;  trl_drops <= '0;
            trailer_pend <= 1'b0;   single_pend <= 1'b0;  defer_valid <= 1'b0;
            single_word <= '0;      defer_word <= '0;     data_q <= '0;
            write_q <= 1'b0;        out_old <= 1'b0;      out_trl <= 1'b0;
            overflow_q <= 1'b0;     drop_q <= '0;
        end else if (!run) begin
            state <= ST_IDLE;       base_cnt <= '0;
            frame_cnt <= '0;        frame_words <= '0;    frame_id <= '0;     frame_drops <= '0;
            trailer_pend <= 1'b0;   single_pend <= 1'b0;  defer_valid <= 1'b0;
            write_q <= 1'b0;        out_old <= 1'b0;      out_trl <= 1'b0;
            overflow_q <= 1'b0;     drop_q <= '0;
        end else begin
            state    <= state_nxt;
            base_cnt <= cnt_nxt;
            if (add_base) base_hold[base_cnt[1:0]] <= bus.sample_in[5:0];
            if (hold_sig) sig_hold <= bus.sample_in;

            write_q <= load;
            out_old <= load_old;
            out_trl <= load_trl;
            if (load) data_q <= load_word;

            if (single_pend) single_pend <= 1'b0;
            else if (trailer_pend) trailer_pend <= 1'b0;
            if (new_valid && !take_new) begin
                defer_valid <= 1'b1;
                defer_word  <= new_word;
            end else if (defer_valid && !single_pend && !trailer_pend) begin
                defer_valid <= 1'b0;
            end
            if (split) begin
                single_pend <= 1'b1;
                single_word <= single_fmt;
            end

            if (drop_now) begin
                overflow_q <= 1'b1;
                drop_q     <= sat_inc8(drop_q);
            end

            if (frame_end) begin
                frame_cnt    <= '0;
                frame_id     <= frame_id + 8'd1;
                trl_id       <= frame_id;
                trl_words    <= frame_words + words_add;
                trl_drops    <= frame_drops_cur;
                frame_words  <= '0;
                frame_drops  <= '0;
                trailer_pend <= 1'b1;
            end else begin
                if (accept) frame_cnt <= frame_cnt + 12'd1;
                frame_words <= frame_words + words_add;
                frame_drops <= frame_drops_cur;
                trl_drops   <= trl_drops_cur;
            end
        end
    end

    assign bus.data_out_32  = data_q;
    assign bus.write_signal = write_q;
    assign bus.overflow     = overflow_q;
    assign bus.drop_cnt     = drop_q;

endmodule

// File: tb/tb_ldtu_sample_packer.sv
// Scoreboard bench for ldtu_sample_packer: one instance with 100-sample frames, one with 4-sample frames.
module tb_ldtu_sample_packer;
    import ldtu_pkg::*;

    typedef struct packed {
        logic [31:0] word;
        logic        drop;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    exp_t q0[$];
    exp_t q1[$];
    exp_t e0, e1;

    always #5 clk = ~clk;

    ldtu_sample_packer_if bus0();
    ldtu_sample_packer_if bus1();

    ldtu_sample_packer #(.FRAME_SAMPLES(100), .BASE_MAX(63)) dut0 (
        .CLK(clk), .reset(rst), .bus(bus0.slave)
    );

    ldtu_sample_packer #(.FRAME_SAMPLES(4), .BASE_MAX(63)) dut1 (
        .CLK(clk), .reset(rst), .bus(bus1.slave)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h, want %h", name, act, req);
        end
    endtask

    // Monitors: pop and compare on every write strobe; the entry also says whether the FIFO reports full.
    always @(negedge clk) begin
        if (!rst && bus0.write_signal) begin
            if (q0.size() == 0) begin
                checks++; failures++;
                $display("FAIL dut0_unexpected_write: got %h, want no write", bus0.data_out_32);
                bus0.full_signal = 1'b0;
            end else begin
                e0 = q0.pop_front();
                check("dut0_word", bus0.data_out_32, e0.word);
                bus0.full_signal = e0.drop;
            end
        end else begin
            bus0.full_signal = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (!rst && bus1.write_signal) begin
            if (q1.size() == 0) begin
                checks++; failures++;
                $display("FAIL dut1_unexpected_write: got %h, want no write", bus1.data_out_32);
                bus1.full_signal = 1'b0;
            end else begin
                e1 = q1.pop_front();
                check("dut1_word", bus1.data_out_32, e1.word);
                bus1.full_signal = e1.drop;
            end
        end else begin
            bus1.full_signal = 1'b0;
        end
    end

    task automatic exp0(input logic [31:0] w, input logic d);
        q0.push_back('{word: w, drop: d});
    endtask

    task automatic exp1(input logic [31:0] w);
        q1.push_back('{word: w, drop: 1'b0});
    endtask

    task automatic send0(input logic [12:0] s);
        bus0.sample_valid = 1'b1;
        bus0.sample_in    = s;
        @(posedge clk); #1;
        bus0.sample_valid = 1'b0;
    endtask

    task automatic send1(input logic [12:0] s);
        bus1.sample_valid = 1'b1;
        bus1.sample_in    = s;
        @(posedge clk); #1;
        bus1.sample_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    function automatic logic [31:0] bfull(input logic [5:0] a, b, c, d, e);
        return {HDR_BASE, e, d, c, b, a};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] smp [5];
        logic [5:0] v;
        int drain;

        bus0.sample_valid = 1'b0; bus0.sample_in = '0; bus0.flush = 1'b1;
        bus1.sample_valid = 1'b0; bus1.sample_in = '0; bus1.flush = 1'b1;

        #12;
        check("reset_data", bus0.data_out_32, 32'h0);
        check("reset_write", {31'd0, bus0.write_signal}, 32'd0);
        check("reset_overflow", {31'd0, bus0.overflow}, 32'd0);
        check("reset_drop_cnt", {24'd0, bus0.drop_cnt}, 32'd0);
        rst = 1'b0;
        idle(2);

        // Five baselines -> one BASE full word, strobed the cycle after the fifth.
        exp0(32'h45103081, 1'b0);
        send0(13'd1); send0(13'd2); send0(13'd3); send0(13'd4);
        check("t1_no_early_write", {31'd0, bus0.write_signal}, 32'd0);
        send0(13'd5);
        check("t1_latency_write", {31'd0, bus0.write_signal}, 32'd1);
        check("t1_latency_data", bus0.data_out_32, 32'h45103081);
        idle(2);

        // Two baselines interrupted by a signal sample, then a signal pair.
        exp0(32'h22000247, 1'b0);
        exp0(32'h29002800, 1'b0);
        send0(13'd7); send0(13'd9); send0(13'h0800); send0(13'h0801);
        idle(3);

        // Three held baselines discarded by flush; frame restarts.
        send0(13'd11); send0(13'd12); send0(13'd13);
        bus0.flush = 1'b0;
        @(posedge clk); #1;
        bus0.flush = 1'b1;
        check("flush_no_write", {31'd0, bus0.write_signal}, 32'd0);
        idle(2);

        // Full 100-sample frame of baselines; the third word is refused by the FIFO.
        for (int i = 0; i < 100; i++) begin
            v = 6'((i * 7) % 64);
            smp[i % 5] = v;
            if (i % 5 == 4) exp0(bfull(smp[0], smp[1], smp[2], smp[3], smp[4]), (i / 5) == 2);
            send0({7'd0, v});
        end
        exp0(32'hD0001401, 1'b0);
        idle(3);
        check("t4_overflow", {31'd0, bus0.overflow}, 32'd1);
        check("t4_drop_cnt", {24'd0, bus0.drop_cnt}, 32'd1);

        // Four-sample frames: BASE part at frame end, trailer in the following cycle.
        exp1(32'h2428A28A);
        exp1(32'hD0000100);
        exp1(32'h24CA8794);
        exp1(32'hD0100100);
        send1(13'd10); send1(13'd10); send1(13'd10); send1(13'd10);
        send1(13'd20);
        check("t3_trailer_write", {31'd0, bus1.write_signal}, 32'd1);
        check("t3_trailer_data", bus1.data_out_32, 32'hD0000100);
        send1(13'd30); send1(13'd40); send1(13'd50);
        idle(3);

        // Frame ending on a signal sample while a baseline is held: BASE part, SIG single, trailer.
        exp1(32'h29002800);
        exp1(32'h21000005);
        exp1(32'h2C000900);
        exp1(32'hD0200300);
        send1(13'h0800); send1(13'h0801); send1(13'd5); send1(13'h0900);
        idle(4);

        // Flush with one sample held: frame id and sample count restart.
        send1(13'd7);
        bus1.flush = 1'b0;
        @(posedge clk); #1;
        bus1.flush = 1'b1;
        exp1(32'h29202900);
        exp1(32'h29206902);
        exp1(32'hD0000200);
        send1(13'h0900); send1(13'h0901); send1(13'h0902); send1(13'h0903);
        idle(4);

        // Asynchronous reset with a signal sample held.
        send0(13'h0900);
        #3 rst = 1'b1;
        #1;
        check("t6_reset_data", bus0.data_out_32, 32'h0);
        check("t6_reset_write", {31'd0, bus0.write_signal}, 32'd0);
        check("t6_reset_overflow", {31'd0, bus0.overflow}, 32'd0);
        check("t6_reset_drop_cnt", {24'd0, bus0.drop_cnt}, 32'd0);
        #2 rst = 1'b0;
        @(posedge clk); #1;
        exp0(32'h29FFF000, 1'b0);
        send0(13'h1000); send0(13'h0FFF);
        check("t6_pair_write", {31'd0, bus0.write_signal}, 32'd1);
        idle(3);

        drain = 0;
        while ((q0.size() != 0 || q1.size() != 0) && drain < 50) begin
            idle(1);
            drain++;
        end
        check("q0_drained", q0.size(), 32'd0);
        check("q1_drained", q1.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
